sys_array_feeder: RTL and testbench
===================================

SYS_ARRAY_FEEDER -- requirements
Module: sys_array_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8: element width in bits.
REQ-002 Parameter ARRAY_W, default 4: array rows, one per output port of the array.
REQ-003 Parameter ARRAY_L, default 4: array columns, one per input port of the array.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 w_load_start  input  1  request to latch a weight matrix, honoured in IDLE only.
REQ-007 w_data  input  ARRAY_W*ARRAY_L*DATA_WIDTH  weight matrix; element [i][j] at bits (i*ARRAY_L+j)*DATA_WIDTH upward.
REQ-008 s_valid  input  1  input vector valid.
REQ-009 s_ready  output  1  feeder accepts a vector this cycle.
REQ-010 s_data  input  ARRAY_L*DATA_WIDTH  input vector; element j at bits j*DATA_WIDTH upward.
REQ-011 s_last  input  1  marks the final vector of a batch.
REQ-012 param_load  output  1  weight-load strobe to the array.
REQ-013 parameter_data  output  ARRAY_W*ARRAY_L*DATA_WIDTH  registered weights, same layout as w_data.
REQ-014 input_module  output  ARRAY_L*DATA_WIDTH  skewed column inputs to the array.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of DRAIN.

Function
REQ-017 FSM states: IDLE, LOAD, STREAM, DRAIN.
REQ-018 IDLE: w_load_start=1 -> capture w_data into parameter_data and go to LOAD; no other input has any effect.
REQ-019 LOAD: param_load=1 for exactly one cycle, then STREAM; param_load=0 in every other state.
REQ-020 STREAM: s_ready=1; s_ready=0 in all other states.
REQ-021 Accepted vector (s_valid&s_ready): element j appears on input_module column j exactly j+1 cycles after the accept edge (column 0 one cycle, column ARRAY_L-1 ARRAY_L cycles).
REQ-022 Skew pipeline shifts every cycle in all states; a cycle with no accept injects zero into column 0 and the stage-0 register of every column.
REQ-023 Accept with s_last=1 -> DRAIN on the next edge.
REQ-024 DRAIN: inject zeros for ARRAY_L+ARRAY_W-1 cycles via a down-counter; on expiry, done=1 for one cycle and the FSM goes to IDLE.
REQ-025 parameter_data holds its value until the next IDLE capture; it is not cleared by DRAIN or done.
REQ-026 w_load_start outside IDLE is ignored; s_valid outside STREAM is ignored and no data is lost silently (s_ready=0).
REQ-027 Back-to-back accepts every cycle are supported with no bubbles.

Reset
REQ-028 reset=1 forces IDLE, clears all skew registers, the drain counter and parameter_data, and drives param_load, s_ready, busy, done and input_module to 0 on the next edge.
REQ-029 Reset asserted mid-STREAM or mid-DRAIN aborts the batch; no done pulse is produced.

Configuration
REQ-030 Macro SYS_ARRAY_FEEDER_CNT_EN defined: add output vec_count (16 bits), cleared on reset and on entering LOAD, incremented per accepted vector, saturating at 16'hFFFF, held after DRAIN.
REQ-031 Macro undefined: no vec_count port and no counter logic; all other behaviour is identical.

Verification (DATA_WIDTH=8, ARRAY_W=4, ARRAY_L=4)
REQ-032 Weight load: w_load_start=1 in IDLE with w_data=0x0F..00 -> parameter_data equals w_data next cycle, and param_load is high for exactly one cycle.
REQ-033 Single vector: s_data={04,03,02,01} with s_last=1 -> input_module column 0=01 at accept+1, column 1=02 at +2, column 2=03 at +3, column 3=04 at +4; all other cycles are zero.
REQ-034 Burst of 3 vectors on consecutive cycles, last with s_last=1 -> each column shows 3 consecutive values; done pulses 7 cycles after the first DRAIN cycle, then busy=0.
REQ-035 Gap: s_valid low for 2 cycles between two vectors -> two zero entries per column between the vectors, with skew preserved.
REQ-036 Reset asserted during DRAIN -> IDLE next cycle, input_module=0, no done pulse, and w_load_start is accepted immediately after.
REQ-037 With SYS_ARRAY_FEEDER_CNT_EN defined: 5 vectors accepted -> vec_count=5 after done; a new LOAD clears it to 0.

Source files
------------

// File: rtl/sys_array_feeder.sv
// Weight-stationary systolic array feeder: latches weights, then skews input vectors into the array columns.
// Optional macro SYS_ARRAY_FEEDER_CNT_EN adds a saturating 16-bit accepted-vector counter (vec_count).
module sys_array_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W    = 4,
  parameter int unsigned ARRAY_L    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_load_start,
  input  logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0] w_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [ARRAY_L*DATA_WIDTH-1:0]         s_data,
  input  logic                                  s_last,
  output logic                                  param_load,
  output logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0] parameter_data,
  output logic [ARRAY_L*DATA_WIDTH-1:0]         input_module,
  output logic                                  busy,
  output logic                                  done
`ifdef SYS_ARRAY_FEEDER_CNT_EN
  ,
  output logic [15:0]                           vec_count
`endif
);

  localparam int unsigned DRAIN_CYCLES = ARRAY_L + ARRAY_W - 1;
  localparam int unsigned CNT_W        = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t           state;
  state_t           state_next;
  logic             done_next;
  logic [CNT_W-1:0] drain_cnt;
  logic             accept;

  // s_ready is high exactly while in STREAM, so this is the handshake
  assign accept = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:    if (w_load_start) state_next = LOAD;
      LOAD:    state_next = STREAM;
      STREAM:  if (accept && s_last) state_next = DRAIN;
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      param_load <= 1'b0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      param_load <= (state_next == LOAD);
      s_ready    <= (state_next == STREAM);
      busy       <= (state_next != IDLE);
      done       <= done_next;
    end
  end

  // Loaded with one less than the drain length; expiry is seen at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (state != DRAIN && state_next == DRAIN) begin
      drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
    end else if (state == DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                            parameter_data <= '0;
    else if (state == IDLE && w_load_start) parameter_data <= w_data;
  end

  // Column j is a (j+1)-deep shift register; idle cycles inject zero
  for (genvar j = 0; j < ARRAY_L; j++) begin : g_col
    logic [DATA_WIDTH-1:0]         inj;
    logic [(j+1)*DATA_WIDTH-1:0]   sr;

    assign inj = accept ? s_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;

    if (j == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset) sr <= '0;
        else       sr <= inj;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (reset) sr <= '0;
        else       sr <= {sr[j*DATA_WIDTH-1:0], inj};
      end
    end

    assign input_module[j*DATA_WIDTH +: DATA_WIDTH] = sr[(j+1)*DATA_WIDTH-1 -: DATA_WIDTH];
  end

`ifdef SYS_ARRAY_FEEDER_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_count <= '0;
    end else if (state == IDLE && state_next == LOAD) begin
      vec_count <= '0;
    end else if (accept && vec_count != 16'hFFFF) begin
      vec_count <= vec_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// Self-checking bench for sys_array_feeder: cycle-level reference model plus directed literal checks.
module tb_sys_array_feeder;

  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int AL      = 4;
  localparam int WGT_W   = AW * AL * DW;
  localparam int VEC_W   = AL * DW;
  localparam int DRAIN_N = AL + AW - 1;
  localparam int SCHED_N = 4096;

  logic             clk = 1'b0;
  logic             reset;
  logic             w_load_start;
  logic [WGT_W-1:0] w_data;
  logic             s_valid;
  logic             s_ready;
  logic [VEC_W-1:0] s_data;
  logic             s_last;
  logic             param_load;
  logic [WGT_W-1:0] parameter_data;
  logic [VEC_W-1:0] input_module;
  logic             busy;
  logic             done;
`ifdef SYS_ARRAY_FEEDER_CNT_EN
  logic [15:0]      vec_count;
`endif

  sys_array_feeder #(.DATA_WIDTH(DW), .ARRAY_W(AW), .ARRAY_L(AL)) dut (
    .clk            (clk),
    .reset          (reset),
    .w_load_start   (w_load_start),
    .w_data         (w_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .param_load     (param_load),
    .parameter_data (parameter_data),
    .input_module   (input_module),
    .busy           (busy),
    .done           (done)
`ifdef SYS_ARRAY_FEEDER_CNT_EN
    ,
    .vec_count      (vec_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0 idle, 1 load, 2 stream, 3 drain
  int               m_phase = 0;
  int               m_drain = 0;
  bit               m_done  = 1'b0;
  logic [WGT_W-1:0] m_param = '0;
  logic [15:0]      m_vc    = '0;
  logic [DW-1:0]    sched [0:SCHED_N-1][0:AL-1];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    for (int c = 0; c < SCHED_N; c++)
      for (int j = 0; j < AL; j++) sched[c][j] = '0;
  end

  always @(posedge clk) begin : model
    bit acc;
    acc = !reset && s_valid && (m_phase == 2);
    if (reset) begin
      m_phase = 0;
      m_drain = 0;
      m_done  = 1'b0;
      m_param = '0;
      m_vc    = '0;
      for (int k = 1; k <= AL; k++)
        for (int j = 0; j < AL; j++) sched[cyc+k][j] = '0;
      chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (acc) begin
        for (int j = 0; j < AL; j++) sched[cyc+1+j][j] = s_data[j*DW +: DW];
        if (m_vc != 16'hFFFF) m_vc = m_vc + 16'd1;
      end
      case (m_phase)
        0: if (w_load_start) begin m_param = w_data; m_phase = 1; m_vc = '0; end
        1: m_phase = 2;
        2: if (acc && s_last) begin m_phase = 3; m_drain = DRAIN_N; end
        default: begin
          m_drain = m_drain - 1;
          if (m_drain == 0) begin m_phase = 0; m_done = 1'b1; end
        end
      endcase
    end
    cyc = cyc + 1;
    if (cyc > 3000) begin
      $display("FAIL watchdog: got cycle %0d expected completion before 3000", cyc);
      $fatal(1);
    end
  end

  always @(negedge clk) begin : compare
    logic [VEC_W-1:0] e_im;
    if (chk_en) begin
      for (int j = 0; j < AL; j++) e_im[j*DW +: DW] = sched[cyc][j];
      check("busy",           128'(busy),           128'(m_phase != 0));
      check("s_ready",        128'(s_ready),        128'(m_phase == 2));
      check("param_load",     128'(param_load),     128'(m_phase == 1));
      check("done",           128'(done),           128'(m_done));
      check("parameter_data", 128'(parameter_data), 128'(m_param));
      check("input_module",   128'(input_module),   128'(e_im));
`ifdef SYS_ARRAY_FEEDER_CNT_EN
      check("vec_count",      128'(vec_count),      128'(m_vc));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [WGT_W-1:0] wd);
    w_load_start = 1'b1;
    w_data       = wd;
    tick();
    w_load_start = 1'b0;
    tick();
  endtask

  task automatic send(input logic [VEC_W-1:0] v, input logic last);
    s_valid = 1'b1;
    s_data  = v;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'hDEADBEEF;
  endtask

  task automatic wait_done(input int exp_n, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, 128'(n), 128'(exp_n));
  endtask

  localparam logic [WGT_W-1:0] WD1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [WGT_W-1:0] WD2 = 128'hA5A5A5A5_12345678_CAFEF00D_00FF00FF;
  localparam logic [WGT_W-1:0] WD3 = 128'h11111111_22222222_33333333_44444444;

  initial begin
    reset = 1'b1; w_load_start = 1'b0; w_data = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    tick();
    tick();
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_param", 128'(parameter_data), 128'(0));
    check("reset_im", 128'(input_module), 128'(0));
    reset = 1'b0;

    // s_valid in IDLE must not reach the array
    s_valid = 1'b1; s_data = 32'hDEADBEEF;
    tick(); tick();
    s_valid = 1'b0;
    check("idle_ignore_im", 128'(input_module), 128'(0));

    // Weight load
    w_load_start = 1'b1; w_data = WD1;
    tick();
    w_load_start = 1'b0;
    check("load_strobe", 128'(param_load), 128'(1));
    check("load_weights", 128'(parameter_data), 128'(WD1));
    tick();
    check("load_strobe_off", 128'(param_load), 128'(0));
    check("stream_ready", 128'(s_ready), 128'(1));

    // Single vector
    send(32'h04030201, 1'b1);
    check("single_c0", 128'(input_module), 128'(32'h00000001));
    tick();
    check("single_c1", 128'(input_module), 128'(32'h00000200));
    tick();
    check("single_c2", 128'(input_module), 128'(32'h00030000));
    tick();
    check("single_c3", 128'(input_module), 128'(32'h04000000));
    wait_done(4, "single_done_latency");
    check("single_done_busy", 128'(busy), 128'(0));
    check("weights_held", 128'(parameter_data), 128'(WD1));

    // Burst of three with an ignored weight load mid-stream
    do_load(WD2);
    w_load_start = 1'b1; w_data = WD3;
    s_valid = 1'b1; s_data = 32'h13121110; s_last = 1'b0;
    tick();
    w_load_start = 1'b0;
    check("burst_t1", 128'(input_module), 128'(32'h00000010));
    s_data = 32'h23222120;
    tick();
    check("burst_t2", 128'(input_module), 128'(32'h00001120));
    s_data = 32'h33323130; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    check("burst_t3", 128'(input_module), 128'(32'h00122130));
    wait_done(DRAIN_N, "burst_done_latency");
    check("burst_weights_kept", 128'(parameter_data), 128'(WD2));

    // Two-cycle gap between vectors
    do_load(WD1);
    send(32'h54535251, 1'b0);
    check("gap_a0", 128'(input_module), 128'(32'h00000051));
    tick();
    tick();
    send(32'h64636261, 1'b1);
    check("gap_mix", 128'(input_module), 128'(32'h54000061));
    wait_done(DRAIN_N, "gap_done_latency");

    // Reset during DRAIN, then immediate reload
    do_load(WD2);
    send(32'h44434241, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_drain_busy", 128'(busy), 128'(0));
    check("rst_drain_im", 128'(input_module), 128'(0));
    check("rst_drain_done", 128'(done), 128'(0));
    reset = 1'b0;
    w_load_start = 1'b1; w_data = WD3;
    tick();
    w_load_start = 1'b0;
    check("rst_reload_strobe", 128'(param_load), 128'(1));
    check("rst_reload_weights", 128'(parameter_data), 128'(WD3));
    tick();

    // Five-vector batch
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = {8'(8'h80 + k), 8'(8'h70 + k), 8'(8'h60 + k), 8'(8'h50 + k)};
      s_last  = (k == 4);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_done(DRAIN_N, "five_done_latency");
`ifdef SYS_ARRAY_FEEDER_CNT_EN
    check("count_five", 128'(vec_count), 128'(5));
    w_load_start = 1'b1; w_data = WD1;
    tick();
    w_load_start = 1'b0;
    check("count_cleared", 128'(vec_count), 128'(0));
    tick();
`endif
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
